// File: rtl/snake_body.sv
// snake_body: segment ring buffer, head movement, apple capture and collision checks.
// Define SNAKE_WRAP_EN to make the playfield edges wrap instead of ending the game.
module snake_body #(
  parameter int MAX_LEN = 64,
  parameter int START_I = 8,
  parameter int START_J = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     tick,
  input  logic                     dir_valid,
  input  logic [1:0]               dir_in,
  input  logic [3:0]               i_apple,
  input  logic [3:0]               j_apple,
  output logic [15:0][15:0]        GrnPixels,
  output logic                     eaten,
  output logic                     game_over,
  output logic [7:0]               score,
  output logic [$clog2(MAX_LEN):0] length
);

  // state  | meaning
  // S_IDLE | waiting for start, ticks ignored
  // S_RUN  | head advances one cell per tick
  // S_OVER | collision seen, everything frozen until reset
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

  localparam int PW = $clog2(MAX_LEN);
  localparam logic [PW:0] LEN_FULL = (PW+1)'(MAX_LEN);
  localparam logic [3:0] SI  = 4'(START_I);
  localparam logic [3:0] SJ0 = 4'(START_J);
  localparam logic [3:0] SJ1 = 4'(START_J - 1);
  localparam logic [3:0] SJ2 = 4'(START_J - 2);

  localparam logic [1:0] D_UP    = 2'b00;
  localparam logic [1:0] D_RIGHT = 2'b01;
  localparam logic [1:0] D_DOWN  = 2'b10;
  localparam logic [1:0] D_LEFT  = 2'b11;

  state_t state_q, state_d;

  logic [3:0]    seg_i [MAX_LEN];
  logic [3:0]    seg_j [MAX_LEN];
  logic [PW-1:0] head_ptr, tail_ptr, head_nxt;
  logic [1:0]    cur_dir, pend_dir, eff_dir;
  logic [3:0]    head_i, head_j, tail_i, tail_j, nxt_i, nxt_j;
  logic          dir_accept, wall, grow, at_tail, hit, drop_tail, move;

  function automatic logic [1:0] reverse_of(input logic [1:0] d);
    case (d)
      D_UP:    reverse_of = D_DOWN;
      D_RIGHT: reverse_of = D_LEFT;
      D_DOWN:  reverse_of = D_UP;
      default: reverse_of = D_RIGHT;
    endcase
  endfunction

  function automatic logic [15:0][15:0] start_bitmap();
    logic [15:0][15:0] b;
    b = '0;
    b[SI][SJ0] = 1'b1;
    b[SI][SJ1] = 1'b1;
    b[SI][SJ2] = 1'b1;
    return b;
  endfunction

  assign head_i   = seg_i[head_ptr];
  assign head_j   = seg_j[head_ptr];
  assign tail_i   = seg_i[tail_ptr];
  assign tail_j   = seg_j[tail_ptr];
  assign head_nxt = head_ptr + PW'(1);

  // A same-cycle dir_valid takes part in the tick it arrives with.
  assign dir_accept = dir_valid && (dir_in != reverse_of(cur_dir)) && (state_q != S_OVER);
  assign eff_dir    = dir_accept ? dir_in : pend_dir;

  always_comb begin
    nxt_i = head_i;
    nxt_j = head_j;
    wall  = 1'b0;
    case (eff_dir)
      D_UP: begin
        nxt_i = head_i - 4'd1;
        wall  = (head_i == 4'd0);
      end
      D_RIGHT: begin
        nxt_j = head_j + 4'd1;
        wall  = (head_j == 4'd15);
      end
      D_DOWN: begin
        nxt_i = head_i + 4'd1;
        wall  = (head_i == 4'd15);
      end
      default: begin
        nxt_j = head_j - 4'd1;
        wall  = (head_j == 4'd0);
      end
    endcase
`ifdef SNAKE_WRAP_EN
    wall = 1'b0;
`endif
  end

  assign grow      = (nxt_i == i_apple) && (nxt_j == j_apple);
  assign at_tail   = (nxt_i == tail_i) && (nxt_j == tail_j);
  // The tail cell is only free when it is about to be vacated.
  assign hit       = GrnPixels[nxt_i][nxt_j] && !(at_tail && !grow);
  assign drop_tail = !grow || (length == LEN_FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    move    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (tick) begin
          if (wall || hit) state_d = S_OVER;
          else             move    = 1'b1;
        end
      end
      S_OVER:  state_d = S_OVER;
      default: state_d = S_IDLE;
    endcase
  end

  assign game_over = (state_q == S_OVER);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_i[k] <= (k < 3) ? SI : 4'd0;
        seg_j[k] <= (k == 0) ? SJ2 : (k == 1) ? SJ1 : (k == 2) ? SJ0 : 4'd0;
      end
      head_ptr  <= PW'(2);
      tail_ptr  <= '0;
      length    <= (PW+1)'(3);
      GrnPixels <= start_bitmap();
      cur_dir   <= D_RIGHT;
      pend_dir  <= D_RIGHT;
      eaten     <= 1'b0;
      score     <= 8'd0;
    end else begin
      eaten <= 1'b0;
      if (dir_accept) pend_dir <= dir_in;
      if (move) begin
        cur_dir         <= eff_dir;
        head_ptr        <= head_nxt;
        seg_i[head_nxt] <= nxt_i;
        seg_j[head_nxt] <= nxt_j;
        if (drop_tail) begin
          GrnPixels[tail_i][tail_j] <= 1'b0;
          tail_ptr                  <= tail_ptr + PW'(1);
        end else begin
          length <= length + (PW+1)'(1);
        end
        // Set after clear so a head entering the vacated tail cell keeps its bit.
        GrnPixels[nxt_i][nxt_j] <= 1'b1;
        if (grow) begin
          eaten <= 1'b1;
          if (score != 8'hFF) score <= score + 8'd1;
        end
      end
    end
  end

endmodule
